// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel and the
// valid/ready handshake towards decode.
interface fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [ADDR_W-1:0] inst_pc;
    logic [DATA_W-1:0] inst_data;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output inst_valid, inst_pc, inst_data,
        input  inst_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  inst_valid, inst_pc, inst_data,
        output inst_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one fetch per PC value, single outstanding request,
// stale responses dropped after a redirect, one-entry output buffer to decode.
module fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_ce,
    input  logic              redirect,
    output logic              hold_pc,
    fetch_ctrl_if.master      bus,
    output logic [7:0]        drop_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            state_r;
    logic              started_r;
    logic [ADDR_W-1:0] req_pc_r;
    logic              inst_valid_r;
    logic [ADDR_W-1:0] inst_pc_r;
    logic [DATA_W-1:0] inst_data_r;
    logic [7:0]        drop_cnt_r;

    logic idle_s;
    logic mem_req_s;
    logic issue_s;
    logic fill_s;
    logic discard_s;

    // Request gating plus classification of this cycle's response as fill or discard.
    always_comb begin
        idle_s    = (state_r == ST_IDLE);
        mem_req_s = started_r & pc_ce & idle_s & ~redirect & (~inst_valid_r | bus.inst_ready);
        issue_s   = mem_req_s & bus.mem_gnt;
        fill_s    = 1'b0;
        discard_s = 1'b0;
        case (state_r)
            ST_WAIT: begin
                fill_s    = bus.mem_rvalid & ~redirect;
                discard_s = bus.mem_rvalid & redirect;
            end
            ST_DROP: begin
                fill_s    = 1'b0;
                discard_s = bus.mem_rvalid;
            end
            default: begin
                fill_s    = 1'b0;
                discard_s = 1'b0;
            end
        endcase
    end

    // Outstanding-request tracker; a redirect turns a live request into a stale one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            started_r <= 1'b0;
            req_pc_r  <= '0;
        end else begin
            started_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        state_r  <= ST_WAIT;
                        req_pc_r <= pc;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_rvalid) begin
                        state_r <= ST_IDLE;
                    end else if (redirect) begin
                        state_r <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (bus.mem_rvalid) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Output buffer: a fill never coincides with a drain because issue needs an empty or draining buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_valid_r <= 1'b0;
            inst_pc_r    <= '0;
            inst_data_r  <= '0;
        end else if (fill_s) begin
            inst_valid_r <= 1'b1;
            inst_pc_r    <= req_pc_r;
            inst_data_r  <= bus.mem_rdata;
        end else if (redirect || bus.inst_ready) begin
            inst_valid_r <= 1'b0;
        end
    end

    // Saturating count of discarded responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 8'd0;
        end else if (discard_s && (drop_cnt_r != 8'hff)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    assign hold_pc        = ~issue_s & ~redirect;
    assign bus.mem_req    = mem_req_s;
    assign bus.mem_addr   = pc;
    assign bus.inst_valid = inst_valid_r;
    assign bus.inst_pc    = inst_pc_r;
    assign bus.inst_data  = inst_data_r;
    assign drop_cnt       = drop_cnt_r;

    fetch_ctrl_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .idle       (idle_s),
        .mem_rvalid (bus.mem_rvalid)
    );
endmodule

// Protocol checker: a response with no request outstanding is a memory-side error.
module fetch_ctrl_chk (
    input logic clk,
    input logic rst_n,
    input logic idle,
    input logic mem_rvalid
);
    a_no_rvalid_in_idle: assert property (@(posedge clk) disable iff (!rst_n) !(idle && mem_rvalid));
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: cycle table from reset, scoreboard on delivered packets,
// then drop-counter saturation and asynchronous reset mid-fetch.
module tb_fetch_ctrl;
    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_ce;
    logic        redirect;
    logic        hold_pc;
    logic [7:0]  drop_cnt;

    fetch_ctrl_if #(.ADDR_W(32), .DATA_W(64)) bif ();

    fetch_ctrl #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc       (pc),
        .pc_ce    (pc_ce),
        .redirect (redirect),
        .hold_pc  (hold_pc),
        .bus      (bif),
        .drop_cnt (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        pc_ce, redir, gnt, rv, rdy, live;
        logic [31:0] pc;
        logic        exp_req, exp_hold, exp_ival;
        logic [7:0]  exp_dcnt;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [63:0] mkdata(input logic [31:0] a);
        return {a ^ 32'h5a5a_5a5a, ~a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    task automatic v(input logic ce, rd, g, rv, rdy, lv, input logic [31:0] p,
                     input logic er, eh, ei, input logic [7:0] ed);
        vec_t t;
        t.pc_ce = ce; t.redir = rd; t.gnt = g; t.rv = rv; t.rdy = rdy; t.live = lv;
        t.pc = p; t.exp_req = er; t.exp_hold = eh; t.exp_ival = ei; t.exp_dcnt = ed;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic ce, rd, g, rv, rdy, input logic [31:0] p, input logic [63:0] d);
        pc_ce          = ce;
        redirect       = rd;
        bif.mem_gnt    = g;
        bif.mem_rvalid = rv;
        bif.inst_ready = rdy;
        pc             = p;
        bif.mem_rdata  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every packet handed to decode must match the oldest expected one.
    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (rst_n && bif.inst_valid && bif.inst_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: packet pc 0x%0h delivered, none expected", bif.inst_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", {32'd0, bif.inst_pc}, {32'd0, e.pc});
                chk("sb_data", bif.inst_data, e.data);
            end
        end
    end

    localparam logic [31:0] PA = 32'hbfc0_0000;
    localparam logic [31:0] PB = 32'hbfc0_0008;
    localparam logic [31:0] PC = 32'hbfc0_0010;
    localparam logic [31:0] PJ = 32'h8000_0000;
    localparam logic [31:0] PK = 32'h8000_0100;
    localparam logic [31:0] PL = 32'h8000_0108;
    localparam logic [31:0] PM = 32'h8000_0110;

    initial begin
        logic [31:0] gnt_pc;
        logic [7:0]  exp_d;
        exp_t        e;

        //  ce rd g  rv rdy lv pc   req hold ival dcnt
        v(1, 0, 1, 0, 1, 0, PA, 0, 1, 0, 8'd0);  // started still low
        v(1, 0, 1, 0, 1, 0, PA, 1, 0, 0, 8'd0);  // first grant
        v(1, 0, 1, 1, 1, 1, PB, 0, 1, 0, 8'd0);  // k = 1 response
        v(1, 0, 1, 0, 1, 0, PB, 1, 0, 1, 8'd0);  // drain + issue
        v(1, 0, 1, 1, 0, 1, PC, 0, 1, 0, 8'd0);
        v(1, 0, 1, 0, 0, 0, PC, 0, 1, 1, 8'd0);  // decode stalls
        v(1, 0, 1, 0, 0, 0, PC, 0, 1, 1, 8'd0);
        v(1, 0, 1, 0, 1, 0, PC, 1, 0, 1, 8'd0);  // release: issue with drain
        v(1, 1, 1, 0, 1, 0, PC, 0, 0, 0, 8'd0);  // redirect after grant
        v(1, 0, 1, 0, 1, 0, PJ, 0, 1, 0, 8'd0);  // DROP
        v(1, 0, 1, 1, 1, 0, PJ, 0, 1, 0, 8'd0);  // stale response k = 3
        v(1, 0, 1, 0, 1, 0, PJ, 1, 0, 0, 8'd1);
        v(1, 1, 1, 1, 1, 0, PK, 0, 0, 0, 8'd1);  // redirect with rvalid in WAIT
        for (int i = 0; i < 5; i++) begin
            v(1, 0, 0, 0, 1, 0, PK, 1, 1, 0, 8'd2);  // grant withheld
        end
        v(1, 0, 1, 0, 1, 0, PK, 1, 0, 0, 8'd2);
        v(1, 0, 1, 0, 1, 0, PL, 0, 1, 0, 8'd2);
        v(1, 0, 1, 1, 1, 1, PL, 0, 1, 0, 8'd2);
        v(1, 0, 0, 0, 1, 0, PL, 1, 1, 1, 8'd2);
        v(0, 0, 1, 0, 1, 0, PL, 0, 1, 0, 8'd2);  // pc_ce low
        v(1, 1, 1, 0, 1, 0, PL, 0, 0, 0, 8'd2);  // redirect in IDLE
        v(1, 0, 0, 0, 1, 0, PL, 1, 1, 0, 8'd2);
        v(1, 0, 1, 0, 1, 0, PL, 1, 0, 0, 8'd2);
        v(1, 0, 1, 1, 0, 0, PM, 0, 1, 0, 8'd2);  // fill, later flushed
        v(1, 1, 1, 0, 0, 0, PM, 0, 0, 1, 8'd2);  // redirect clears buffer
        v(1, 0, 0, 0, 1, 0, PM, 1, 1, 0, 8'd2);

        rst_n  = 1'b0;
        gnt_pc = 32'd0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, PA, 64'd0);
        tick();
        tick();
        chk("rst_req", {63'd0, bif.mem_req}, 64'd0);
        chk("rst_hold", {63'd0, hold_pc}, 64'd1);
        chk("rst_ival", {63'd0, bif.inst_valid}, 64'd0);
        chk("rst_dcnt", {56'd0, drop_cnt}, 64'd0);
        chk("rst_ipc", {32'd0, bif.inst_pc}, 64'd0);
        chk("rst_idata", bif.inst_data, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].pc_ce, vecs[i].redir, vecs[i].gnt, vecs[i].rv, vecs[i].rdy,
                  vecs[i].pc, mkdata(gnt_pc));
            if (vecs[i].live) begin
                e.pc   = gnt_pc;
                e.data = mkdata(gnt_pc);
                sb.push_back(e);
            end
            if (vecs[i].exp_req && vecs[i].gnt) gnt_pc = vecs[i].pc;
            @(negedge clk);
            chk($sformatf("r%0d_req", i), {63'd0, bif.mem_req}, {63'd0, vecs[i].exp_req});
            chk($sformatf("r%0d_hold", i), {63'd0, hold_pc}, {63'd0, vecs[i].exp_hold});
            chk($sformatf("r%0d_addr", i), {32'd0, bif.mem_addr}, {32'd0, vecs[i].pc});
            chk($sformatf("r%0d_ival", i), {63'd0, bif.inst_valid}, {63'd0, vecs[i].exp_ival});
            chk($sformatf("r%0d_dcnt", i), {56'd0, drop_cnt}, {56'd0, vecs[i].exp_dcnt});
            tick();
        end

        // 300 fetches, each killed by a redirect that coincides with its response.
        exp_d = 8'd2;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, PA, 64'd0);
            tick();
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, PA, 64'd0);
            @(negedge clk);
            chk("sat_hold", {63'd0, hold_pc}, 64'd0);
            tick();
            exp_d = (exp_d == 8'd255) ? 8'd255 : exp_d + 8'd1;
            chk("sat_dcnt", {56'd0, drop_cnt}, {56'd0, exp_d});
        end
        chk("sat_final", {56'd0, drop_cnt}, 64'd255);

        // Asynchronous reset while a request is outstanding.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, PB, 64'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, PB, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {63'd0, bif.mem_req}, 64'd0);
        chk("arst_hold", {63'd0, hold_pc}, 64'd1);
        chk("arst_ival", {63'd0, bif.inst_valid}, 64'd0);
        chk("arst_dcnt", {56'd0, drop_cnt}, 64'd0);
        chk("arst_ipc", {32'd0, bif.inst_pc}, 64'd0);
        chk("arst_idata", bif.inst_data, 64'd0);
        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
